// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: flushes IF/ID on a resolved branch, issues a valid/ready
// PC redirect, then drains IF for DRAIN_CYCLES. Define BRANCH_STATS_EN for statistics counters.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [1:0]       ex_branch,
  input  logic             ex_is_cond,
  input  logic [XLEN-1:0]  ex_target,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic             flush_if,
  output logic             flush_id,
  output logic             hold_ex,
  output logic             busy,
  output logic             misalign_err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_jumps
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            take;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_d        = pc_q;
    mis_d       = 1'b0;
    take        = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    redir_valid = 1'b0;
    hold_ex     = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = ex_valid && (ex_branch != 2'b00);
        if (take) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          pc_d     = {ex_target[XLEN-1:1], 1'b0};
          mis_d    = ex_target[1];
          state_d  = REDIR;
        end
      end
      REDIR: begin
        redir_valid = 1'b1;
        flush_if    = 1'b1;
        hold_ex     = 1'b1;
        if (redir_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        flush_if = 1'b1;
        drain_d  = drain_q - DW'(1);
        if (drain_q <= DW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      pc_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign redir_pc     = pc_q;
  assign misalign_err = mis_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_q, br_d, tk_q, tk_d, jp_q, jp_d;
  logic             stats_unused;

  // Counters see only IDLE-cycle EX events; EX holds bubbles while busy.
  always_comb begin
    br_d = br_q;
    tk_d = tk_q;
    jp_d = jp_q;
    if (stat_clr) begin
      br_d = '0;
      tk_d = '0;
      jp_d = '0;
    end else if (state_q == IDLE && ex_valid) begin
      if (ex_is_cond && br_q != '1)        br_d = br_q + CNT_W'(1);
      if (ex_branch == 2'b01 && tk_q != '1) tk_d = tk_q + CNT_W'(1);
      if (ex_branch[1] && jp_q != '1)       jp_d = jp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q <= '0;
      tk_q <= '0;
      jp_q <= '0;
    end else begin
      br_q <= br_d;
      tk_q <= tk_d;
      jp_q <= jp_d;
    end
  end

  assign stat_branches = br_q;
  assign stat_taken    = tk_q;
  assign stat_jumps    = jp_q;
  assign stats_unused  = ex_target[0];
`else
  logic stats_unused;

  assign stat_branches = '0;
  assign stat_taken    = '0;
  assign stat_jumps    = '0;
  assign stats_unused  = ^{ex_target[0], stat_clr, ex_is_cond};
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus randomized bench for branch_redirect_ctrl against a cycle-level
// behavioural model of the redirect protocol and statistics counters.
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int DRAIN = 2;
  localparam int CNT_W = 32;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ex_valid = 1'b0;
  logic [1:0]       ex_branch = 2'b00;
  logic             ex_is_cond = 1'b0;
  logic [XLEN-1:0]  ex_target = '0;
  logic             redir_ready = 1'b0;
  logic             stat_clr = 1'b0;
  logic             redir_valid, flush_if, flush_id, hold_ex, busy, misalign_err;
  logic [XLEN-1:0]  redir_pc;
  logic [CNT_W-1:0] stat_branches, stat_taken, stat_jumps;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .XLEN(XLEN),
    .DRAIN_CYCLES(DRAIN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .ex_branch(ex_branch),
    .ex_is_cond(ex_is_cond),
    .ex_target(ex_target),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .redir_ready(redir_ready),
    .flush_if(flush_if),
    .flush_id(flush_id),
    .hold_ex(hold_ex),
    .busy(busy),
    .misalign_err(misalign_err),
    .stat_clr(stat_clr),
    .stat_branches(stat_branches),
    .stat_taken(stat_taken),
    .stat_jumps(stat_jumps)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: a pending redirect, the number of drain cycles left, plain integer counters.
  bit              m_pending = 1'b0;
  int              m_drain = 0;
  logic [XLEN-1:0] m_pc = '0;
  bit              m_mis = 1'b0;
  longint unsigned m_br = 0, m_tk = 0, m_jp = 0;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 64'd1;

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v >= CMAX) ? v : v + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return m_pending || (m_drain > 0);
  endfunction

  task automatic cycle(input bit r, input bit v, input logic [1:0] b, input bit c,
                       input logic [XLEN-1:0] t, input bit rdy, input bit clr);
    bit idle, take;
    @(negedge clk);
    rst = r; ex_valid = v; ex_branch = b; ex_is_cond = c;
    ex_target = t; redir_ready = rdy; stat_clr = clr;
    #1;
    idle = !m_busy();
    take = idle && v && (b != 2'b00);
    check("flush_if",     64'(flush_if),     64'(take || m_busy()));
    check("flush_id",     64'(flush_id),     64'(take));
    check("redir_valid",  64'(redir_valid),  64'(m_pending));
    check("hold_ex",      64'(hold_ex),      64'(m_pending));
    check("busy",         64'(busy),         64'(m_busy()));
    check("redir_pc",     64'(redir_pc),     64'(m_pc));
    check("misalign_err", 64'(misalign_err), 64'(m_mis));
    check("stat_branches", 64'(stat_branches), STATS ? m_br : 64'd0);
    check("stat_taken",    64'(stat_taken),    STATS ? m_tk : 64'd0);
    check("stat_jumps",    64'(stat_jumps),    STATS ? m_jp : 64'd0);
    @(posedge clk);
    if (r) begin
      m_pending = 1'b0; m_drain = 0; m_pc = '0; m_mis = 1'b0;
      m_br = 0; m_tk = 0; m_jp = 0;
    end else begin
      m_mis = take && t[1];
      if (clr) begin
        m_br = 0; m_tk = 0; m_jp = 0;
      end else if (idle && v) begin
        if (c)            m_br = sat_inc(m_br);
        if (b == 2'b01)   m_tk = sat_inc(m_tk);
        if (b[1])         m_jp = sat_inc(m_jp);
      end
      if (take) begin
        m_pending = 1'b1;
        m_pc = t & ~32'h1;
      end else if (m_pending && rdy) begin
        m_pending = 1'b0;
        m_drain = DRAIN;
      end else if (m_drain > 0) begin
        m_drain--;
      end
    end
  endtask

  task automatic idle_cycle(input bit rdy);
    cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, rdy, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_busy(); i++) idle_cycle(1'b1);
    check("idle_timeout", 64'(m_busy()), 64'd0);
  endtask

  initial begin
    cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
    idle_cycle(1'b0);

    // Taken conditional, ready tied high: T, T+1 redirect, T+2..T+3 drain, T+4 idle
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    #1 check("tc_pc", 64'(redir_pc), 64'h100);
    for (int i = 0; i < 3; i++) idle_cycle(1'b1);
    #1 check("tc_idle", 64'(busy), 64'd0);

    // Backpressure on a jump
    cycle(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle_cycle(1'b0);
      check("bp_pc", 64'(redir_pc), 64'h200);
    end
    idle_cycle(1'b1);
    wait_idle();

    // Branch presented while busy is ignored
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    #1 check("busy_pc", 64'(redir_pc), 64'h100);
    wait_idle();

    // Misaligned target
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0107, 1'b1, 1'b0);
    #1 check("mis_pulse", 64'(misalign_err), 64'd1);
    check("mis_pc", 64'(redir_pc), 64'h106);
    idle_cycle(1'b1);
    #1 check("mis_drop", 64'(misalign_err), 64'd0);
    wait_idle();

    // Reset while in REDIR, then a fresh branch
    cycle(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0504, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
    #1 check("rst_pc", 64'(redir_pc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0600, 1'b1, 1'b0);
    wait_idle();

    // Statistics: 3 conditionals (2 taken), 1 jump, then clear with a taken branch
    cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
    wait_idle();
    cycle(1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0404, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0408, 1'b1, 1'b0);
    wait_idle();
    cycle(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_040c, 1'b1, 1'b0);
    wait_idle();
    #1 check("st_br", 64'(stat_branches), STATS ? 64'd3 : 64'd0);
    check("st_tk", 64'(stat_taken), STATS ? 64'd2 : 64'd0);
    check("st_jp", 64'(stat_jumps), STATS ? 64'd1 : 64'd0);
    cycle(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_0410, 1'b1, 1'b1);
    #1 check("st_clr_br", 64'(stat_branches), 64'd0);
    check("st_clr_tk", 64'(stat_taken), 64'd0);
    check("st_clr_jp", 64'(stat_jumps), 64'd0);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            32'($urandom()),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencer between `branch_unit` and the fetch/decode pipeline registers. It takes the resolved branch decision from EX and kills the younger IF/ID instructions. It then issues a valid/ready PC redirect to the fetch unit and holds bubbles for a fixed drain window before accepting the next branch. It can optionally keep branch statistics counters.

## Interface
- `XLEN`, 32, address width.
- `DRAIN_CYCLES`, 2, number of cycles IF stays flushed after the redirect is accepted (0 allowed).
- `CNT_W`, 32, width of the statistics counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX holds a valid instruction this cycle.
- `ex_branch` in 2: `branch_unit` output; 00 none, 01 conditional taken, 1x unconditional jump.
- `ex_is_cond` in 1: EX instruction is a conditional branch (taken or not).
- `ex_target` in XLEN: computed branch/jump target.
- `redir_valid` out 1: redirect request to fetch.
- `redir_pc` out XLEN: redirect PC, stable while `redir_valid` is high.
- `redir_ready` in 1: fetch accepts the redirect.
- `flush_if` out 1: kill the IF/ID register contents.
- `flush_id` out 1: kill the ID/EX register contents.
- `hold_ex` out 1: stall EX/MEM advance while a redirect is outstanding.
- `busy` out 1: controller is not in IDLE.
- `misalign_err` out 1: one-cycle pulse when the target is not word-aligned.
- `stat_clr` in 1: synchronous clear of the statistics counters.
- `stat_branches`, `stat_taken`, `stat_jumps` out CNT_W: statistics counters.

## Operation
- State machine states: IDLE, REDIR, DRAIN.
- Define `take` = `ex_valid` & (`ex_branch` != 00).
- **IDLE**
  - When `take` is high, `flush_if` and `flush_id` assert combinationally in the same cycle.
  - The target is latched as `{ex_target[XLEN-1:1],1'b0}`.
  - `misalign_err` is registered from `ex_target[1]`.
  - Next state is REDIR.
  - When `take` is low, all outputs stay 0.
- **REDIR**
  - `redir_valid`=1, `flush_if`=1, `hold_ex`=1, `busy`=1.
  - `redir_pc` holds the latched value.
  - On `redir_valid` & `redir_ready`: go to DRAIN with counter = DRAIN_CYCLES, or go straight to IDLE if DRAIN_CYCLES=0.
- **DRAIN**
  - `flush_if`=1, `busy`=1, `redir_valid`=0.
  - The counter decrements each cycle; when it reaches 1, the next state is IDLE.
- `ex_valid` and `ex_branch` are ignored outside IDLE. EX carries only flushed bubbles during that time, and no second redirect is generated.
- A misaligned target still redirects. `misalign_err` is a flag only; bit 1 of the target is kept and bit 0 is cleared.
- `redir_pc` keeps its last value in IDLE and is 0 after reset.

## Timing
- Reset value of every output is 0, including `redir_pc` and the counters. State after reset is IDLE.
- Branch detected at cycle T:
  - `flush_if` and `flush_id` are high in T.
  - `redir_valid`, `hold_ex` and `misalign_err` go high from T+1.
- If the redirect is accepted at cycle A (valid & ready sampled at the edge ending A):
  - DRAIN covers A+1 … A+DRAIN_CYCLES.
  - IDLE resumes at A+DRAIN_CYCLES+1.
  - Minimum branch-to-branch spacing is DRAIN_CYCLES+2 cycles with `redir_ready` tied high.
- `redir_ready` may be high before `redir_valid`; acceptance happens only while in REDIR.
- Once `redir_valid` asserts, it must not drop until acceptance, and `redir_pc` must not change.
- `rst` asserted in any state:
  - At the next edge the block enters IDLE and all outputs are 0.
  - A pending redirect is discarded and counters are cleared.
- `flush_id` is high only in the detect cycle; `flush_if` is high from T through the last DRAIN cycle.

## Configuration
- Macro `BRANCH_STATS_EN` enables the statistics counters.
- **Defined**: counters update only on IDLE-cycle events.
  - `stat_branches` increments on `ex_valid` & `ex_is_cond`.
  - `stat_taken` increments on `ex_valid` & `ex_branch`==01.
  - `stat_jumps` increments on `ex_valid` & `ex_branch[1]`.
  - All counters saturate at all-ones.
  - `stat_clr` takes priority over an increment in the same cycle.
- **Undefined**:
  - The counter ports remain and are tied to 0.
  - `stat_clr` is ignored and no counter flops are built.

## Test plan
- **Taken conditional:**
  - Stimulus: `ex_valid`=1, `ex_branch`=01, `ex_target`=0x0000_0100, `redir_ready`=1, DRAIN_CYCLES=2.
  - Required: T has `flush_if`=`flush_id`=1; T+1 has `redir_valid`=1 with `redir_pc`=0x100; T+2 and T+3 have `flush_if` only; T+4 is IDLE.
- **Backpressure:**
  - Stimulus: jump (`ex_branch`=10) to 0x200 with `redir_ready` low for 5 cycles.
  - Required: `redir_valid` and `hold_ex` stay high and `redir_pc` stays 0x200 throughout; DRAIN starts the cycle after `redir_ready` rises.
- **Branch while busy:**
  - Stimulus: second `ex_branch`=01 to 0x300 during REDIR and DRAIN.
  - Required: no second redirect; `redir_pc` stays at the first target.
- **Misaligned target:**
  - Stimulus: `ex_target`=0x0000_0107.
  - Required: `redir_pc`=0x106; `misalign_err` pulses high for exactly one cycle at T+1.
- **Reset mid-REDIR:**
  - Stimulus: `rst` asserted in REDIR.
  - Required: next cycle all outputs are 0 and the block is in IDLE; a new branch right after reset release is handled normally.
- **Stats (`BRANCH_STATS_EN`):**
  - Stimulus: 3 conditional branches, 2 of them taken, plus 1 jump, then `stat_clr` pulsed together with a new taken branch.
  - Required: counts read 3/2/1 before the clear, then all 0 after the clear cycle.
  - Without the macro, all counters read 0 throughout.
